// File: rtl/ucode_seq.sv
// rtl/ucode_seq.sv - microcode sequencer: next-address mux plus call/return stack.
// Define UCODE_SEQ_STACK_CHECK_EN for saturating stack with sticky ovf/unf; otherwise the stack pointer wraps.
module ucode_seq #(
  parameter int ADR_W = 11,
  parameter int DEPTH = 16,
  parameter int NSRC  = 4,
  parameter logic [ADR_W-1:0] TRAP_MASK = ADR_W'(11'b01111111110)
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [ADR_W-1:0]            j,
  input  logic [$clog2(NSRC+2)-1:0]   disp_sel,
  input  logic [NSRC*ADR_W-1:0]       disp_src,
  input  logic                        cond,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        force_trap,
  output logic [ADR_W-1:0]            cradr,
  output logic [ADR_W-1:0]            ret_adr,
  output logic [$clog2(DEPTH):0]      sp,
  output logic                        stk_full,
  output logic                        stk_empty,
  output logic                        ovf,
  output logic                        unf
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(NSRC+2);

  logic [ADR_W-1:0] stack [DEPTH];
  logic [ADR_W-1:0] disp_val;
  logic [ADR_W-1:0] nxt_adr;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;
  logic             do_push;
  logic             do_pop;
  logic             do_tail;
  logic             push_eff;
  logic             repl_eff;

  // Trap behaves like a call and masks any return in the same microword.
  assign do_push  = force_trap | (call & ~ret);
  assign do_tail  = call & ret & ~force_trap;
  assign do_pop   = ret & ~call & ~force_trap;
  assign push_eff = do_push | (do_tail & stk_empty);
  assign repl_eff = do_tail & ~stk_empty;

  always_comb begin
    disp_val = '0;
    if (disp_sel == SW'(1))
      disp_val = ret_adr;
    for (int k = 0; k < NSRC; k++) begin
      if (disp_sel == SW'(k + 2))
        disp_val = disp_src[k*ADR_W +: ADR_W];
    end
  end

  assign nxt_adr = j | disp_val | (force_trap ? TRAP_MASK : '0) | {{(ADR_W-1){1'b0}}, cond};

  always_ff @(posedge clk) begin
    if (RESET)
      cradr <= '0;
    else
      cradr <= nxt_adr;
  end

  assign ret_adr = stk_empty ? '0 : stack[top_idx];

  // Stack RAM is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!RESET && wr_en)
      stack[wr_idx] <= cradr;
  end

`ifdef UCODE_SEQ_STACK_CHECK_EN
  logic [PW:0] sp_q;

  assign sp        = sp_q;
  assign stk_full  = (sp_q == (PW+1)'(DEPTH));
  assign stk_empty = (sp_q == '0);
  assign top_idx   = sp_q[PW-1:0] - PW'(1);
  assign wr_en     = (push_eff & ~stk_full) | repl_eff;
  assign wr_idx    = repl_eff ? top_idx : sp_q[PW-1:0];

  always_ff @(posedge clk) begin
    if (RESET) begin
      sp_q <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (push_eff) begin
      if (stk_full)
        ovf <= 1'b1;
      else
        sp_q <= sp_q + (PW+1)'(1);
    end else if (do_pop) begin
      if (stk_empty)
        unf <= 1'b1;
      else
        sp_q <= sp_q - (PW+1)'(1);
    end
  end
`else
  logic [PW-1:0] sp_q;

  assign sp        = {1'b0, sp_q};
  assign stk_full  = 1'b0;
  assign stk_empty = (sp_q == '0);
  assign top_idx   = sp_q - PW'(1);
  assign wr_en     = push_eff | repl_eff;
  assign wr_idx    = repl_eff ? top_idx : sp_q;
  assign ovf       = 1'b0;
  assign unf       = 1'b0;

  // Modular pointer: a push past DEPTH-1 overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (RESET)
      sp_q <= '0;
    else if (push_eff)
      sp_q <= sp_q + PW'(1);
    else if (do_pop)
      sp_q <= sp_q - PW'(1);
  end
`endif

endmodule

// File: tb/tb_ucode_seq.sv
// tb/tb_ucode_seq.sv - self-checking bench for ucode_seq with a queue-based reference model.
module tb_ucode_seq;
  localparam int ADR_W = 11;
  localparam int DEPTH = 16;
  localparam int NSRC  = 4;
  localparam logic [10:0] TRAP = 11'h3FE;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] j = '0;
  logic [2:0]  disp_sel = '0;
  logic [43:0] disp_src = {11'h403, 11'h00C, 11'h0F0, 11'h700};
  logic        cond = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        force_trap = 1'b0;
  logic [10:0] cradr;
  logic [10:0] ret_adr;
  logic [4:0]  sp;
  logic        stk_full;
  logic        stk_empty;
  logic        ovf;
  logic        unf;

  int n_assert = 0;
  int n_fail = 0;
  bit run = 0;

  ucode_seq #(.ADR_W(ADR_W), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
    .clk(clk), .RESET(RESET), .j(j), .disp_sel(disp_sel), .disp_src(disp_src),
    .cond(cond), .call(call), .ret(ret), .force_trap(force_trap),
    .cradr(cradr), .ret_adr(ret_adr), .sp(sp), .stk_full(stk_full),
    .stk_empty(stk_empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stack as a queue (saturating) or as circular slots (wrapping).
  logic [10:0] m_cradr;
  bit          m_cok;
`ifdef UCODE_SEQ_STACK_CHECK_EN
  logic [10:0] m_q[$];
  bit          m_ovf;
  bit          m_unf;
`else
  int          m_occ;
  logic [10:0] m_slot[DEPTH];
  bit          m_known[DEPTH];
`endif

  function automatic int m_sp();
`ifdef UCODE_SEQ_STACK_CHECK_EN
    return m_q.size();
`else
    return m_occ;
`endif
  endfunction

  function automatic bit m_rok();
`ifdef UCODE_SEQ_STACK_CHECK_EN
    return 1'b1;
`else
    return (m_occ == 0) || m_known[m_occ-1];
`endif
  endfunction

  function automatic logic [10:0] m_ret();
`ifdef UCODE_SEQ_STACK_CHECK_EN
    return (m_q.size() == 0) ? 11'h0 : m_q[$];
`else
    return (m_occ == 0) ? 11'h0 : m_slot[m_occ-1];
`endif
  endfunction

  task automatic m_push(input logic [10:0] v, input bit ok);
`ifdef UCODE_SEQ_STACK_CHECK_EN
    if (m_q.size() == DEPTH) m_ovf = 1'b1;
    else m_q.push_back(v);
`else
    m_slot[m_occ] = v;
    m_known[m_occ] = ok;
    m_occ = (m_occ + 1) % DEPTH;
`endif
  endtask

  task automatic m_pop();
`ifdef UCODE_SEQ_STACK_CHECK_EN
    if (m_q.size() == 0) m_unf = 1'b1;
    else void'(m_q.pop_back());
`else
    m_occ = (m_occ + DEPTH - 1) % DEPTH;
`endif
  endtask

  task automatic m_tail(input logic [10:0] v, input bit ok);
    if (m_sp() == 0) m_push(v, ok);
    else begin
`ifdef UCODE_SEQ_STACK_CHECK_EN
      m_q[m_q.size()-1] = v;
`else
      m_slot[m_occ-1] = v;
      m_known[m_occ-1] = ok;
`endif
    end
  endtask

  always @(posedge clk) begin
    logic [10:0] dv;
    logic [10:0] nx;
    bit ok;
    dv = 11'h0;
    ok = m_cok;
    if (disp_sel == 3'd1) begin
      dv = m_ret();
      ok = ok && m_rok();
    end else if (int'(disp_sel) >= 2 && int'(disp_sel) <= NSRC + 1) begin
      dv = disp_src[(int'(disp_sel) - 2)*ADR_W +: ADR_W];
    end
    nx = j | dv | (force_trap ? TRAP : 11'h0) | {10'h0, cond};
    if (RESET) begin
      m_cradr = 11'h0;
      m_cok = 1'b1;
`ifdef UCODE_SEQ_STACK_CHECK_EN
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
`else
      m_occ = 0;
`endif
    end else begin
      if (force_trap || (call && !ret)) m_push(m_cradr, m_cok);
      else if (call && ret) m_tail(m_cradr, m_cok);
      else if (ret) m_pop();
      m_cradr = nx;
      m_cok = ok;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      if (m_cok) chk("cmp_cradr", int'(cradr), int'(m_cradr));
      chk("cmp_sp", int'(sp), m_sp());
      if (m_rok()) chk("cmp_ret_adr", int'(ret_adr), int'(m_ret()));
      chk("cmp_stk_empty", int'(stk_empty), int'(m_sp() == 0));
`ifdef UCODE_SEQ_STACK_CHECK_EN
      chk("cmp_stk_full", int'(stk_full), int'(m_sp() == DEPTH));
      chk("cmp_ovf", int'(ovf), int'(m_ovf));
      chk("cmp_unf", int'(unf), int'(m_unf));
`else
      chk("cmp_stk_full", int'(stk_full), 0);
      chk("cmp_ovf", int'(ovf), 0);
      chk("cmp_unf", int'(unf), 0);
`endif
    end
  end

  task automatic cyc(input logic [10:0] jj, input logic [2:0] sel, input logic c,
                     input logic cl, input logic rt, input logic tr);
    j = jj;
    disp_sel = sel;
    cond = c;
    call = cl;
    ret = rt;
    force_trap = tr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    cyc(11'h0AA, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    run = 1;
    cyc(11'h055, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_cradr", int'(cradr), 0);
    chk("rst_sp", int'(sp), 0);
    chk("rst_ret_adr", int'(ret_adr), 0);
    chk("rst_stk_empty", int'(stk_empty), 1);
    chk("rst_stk_full", int'(stk_full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    RESET = 1'b0;

    // basic call / return
    cyc(11'h005, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(11'h010, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("call_cradr", int'(cradr), 'h010);
    chk("call_sp", int'(sp), 1);
    chk("call_ret_adr", int'(ret_adr), 'h005);
    cyc(11'h001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ret_cradr", int'(cradr), 'h005);
    chk("ret_sp", int'(sp), 0);

    // three nested calls, unwound in LIFO order
    cyc(11'h100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(11'h200, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(11'h300, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(11'h400, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("nest_sp", int'(sp), 3);
    chk("nest_tos0", int'(ret_adr), 'h300);
    cyc(11'h000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nest_cradr0", int'(cradr), 'h300);
    chk("nest_tos1", int'(ret_adr), 'h200);
    cyc(11'h000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nest_tos2", int'(ret_adr), 'h100);
    cyc(11'h000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nest_cradr2", int'(cradr), 'h100);
    chk("nest_empty", int'(stk_empty), 1);

    // trap overrides ret
    cyc(11'h123, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("trap_cradr", int'(cradr), 'h3FE);
    chk("trap_sp", int'(sp), 1);
    chk("trap_ret_adr", int'(ret_adr), 'h123);
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // trap with call pushes once
    cyc(11'h0AA, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(11'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("trapcall_sp", int'(sp), 1);
    chk("trapcall_ret_adr", int'(ret_adr), 'h0AA);
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // tail call replaces TOS
    cyc(11'h020, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(11'h040, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(11'h077, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tail_pre_tos", int'(ret_adr), 'h040);
    cyc(11'h050, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tail_sp", int'(sp), 2);
    chk("tail_ret_adr", int'(ret_adr), 'h077);

    // reset mid-subroutine, reset beats call+trap
    RESET = 1'b1;
    cyc(11'h0AA, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    RESET = 1'b0;
    chk("midrst_sp", int'(sp), 0);
    chk("midrst_ret_adr", int'(ret_adr), 0);
    chk("midrst_cradr", int'(cradr), 0);

    // tail call on empty stack acts as push
    cyc(11'h011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(11'h000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tail0_sp", int'(sp), 1);
    chk("tail0_ret_adr", int'(ret_adr), 'h011);

    // dispatch channels, cond, out-of-range select
    cyc(11'h00F, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("disp_ch1", int'(cradr), 'h0FF);
    cyc(11'h00F, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_sel6", int'(cradr), 'h00F);
    cyc(11'h00F, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_sel7", int'(cradr), 'h00F);
    cyc(11'h000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_ch0", int'(cradr), 'h700);
    cyc(11'h000, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_ch3", int'(cradr), 'h403);
    cyc(11'h001, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_ch2", int'(cradr), 'h00D);

    // stack depth boundary
    RESET = 1'b1;
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 16; i++) cyc(11'(i + 1), 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef UCODE_SEQ_STACK_CHECK_EN
    chk("full16_sp", int'(sp), 16);
    chk("full16_full", int'(stk_full), 1);
    chk("full16_tos", int'(ret_adr), 'h00F);
    chk("full16_ovf", int'(ovf), 0);
    cyc(11'h011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("push17_sp", int'(sp), 16);
    chk("push17_ovf", int'(ovf), 1);
    chk("push17_tos", int'(ret_adr), 'h00F);
    for (int i = 0; i < 16; i++) cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_sp", int'(sp), 0);
    chk("drain_ovf_sticky", int'(ovf), 1);
    chk("drain_unf", int'(unf), 0);
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("underflow_unf", int'(unf), 1);
    chk("underflow_sp", int'(sp), 0);
    RESET = 1'b1;
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_unf", int'(unf), 0);
`else
    chk("wrap16_sp", int'(sp), 0);
    chk("wrap16_empty", int'(stk_empty), 1);
    chk("wrap16_full", int'(stk_full), 0);
    cyc(11'h011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap17_sp", int'(sp), 1);
    chk("wrap17_tos", int'(ret_adr), 'h010);
    RESET = 1'b1;
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("popwrap_sp", int'(sp), 15);
    chk("popwrap_tos", int'(ret_adr), 'h00E);
    chk("popwrap_unf", int'(unf), 0);
`endif
    cyc(11'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
